// File: rtl/uds_fetch_if.sv
// rtl/uds_fetch_if.sv - control, UDS responder bus and word stream signals of uds_fetch
interface uds_fetch_if;
  logic        start;
  logic        busy;
  logic        done;
  logic        error;
  logic        uds_cs;
  logic        uds_en;
  logic [2:0]  uds_address;
  logic [31:0] uds_read_data;
  logic        uds_ready;
  logic        word_valid;
  logic        word_ready;
  logic [31:0] word_data;
  logic [2:0]  word_index;

  modport master (
    input  start, uds_read_data, uds_ready, word_ready,
    output busy, done, error, uds_cs, uds_en, uds_address,
           word_valid, word_data, word_index
  );

  modport slave (
    output start, uds_read_data, uds_ready, word_ready,
    input  busy, done, error, uds_cs, uds_en, uds_address,
           word_valid, word_data, word_index
  );
endinterface

// File: rtl/uds_fetch.sv
// rtl/uds_fetch.sv - read-once UDS fetch engine: one bus read per word, streamed out, scrubbed after handoff
module uds_fetch #(
  parameter int unsigned NUM_WORDS      = 8,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  uds_fetch_if.master bus
);
  localparam logic [2:0] LAST_IDX = 3'(NUM_WORDS - 1);
  localparam logic [7:0] TO_LAST  = 8'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_OUT, S_DONE, S_ERROR} state_t;

  state_t      state_q, state_d;
  logic [2:0]  idx_q, idx_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        error_q, error_d;
  logic        cs_q, cs_d;
  logic        en_q, en_d;
  logic [2:0]  addr_q, addr_d;
  logic        valid_q, valid_d;
  logic [31:0] data_q, data_d;
  logic [2:0]  index_q, index_d;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      idx_q   <= 3'd0;
      cnt_q   <= 8'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
      cs_q    <= 1'b0;
      en_q    <= 1'b0;
      addr_q  <= 3'd0;
      valid_q <= 1'b0;
      data_q  <= 32'd0;
      index_q <= 3'd0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      error_q <= error_d;
      cs_q    <= cs_d;
      en_q    <= en_d;
      addr_q  <= addr_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      index_q <= index_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = done_q;
    error_d = error_q;
    cs_d    = cs_q;
    en_d    = en_q;
    addr_d  = addr_q;
    valid_d = valid_q;
    data_d  = data_q;
    index_d = index_q;

    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d = S_REQ;
          idx_d   = 3'd0;
          cnt_d   = 8'd0;
          busy_d  = 1'b1;
          cs_d    = 1'b1;
          en_d    = 1'b1;
          addr_d  = 3'd0;
        end
      end
      S_REQ: begin
        // cs/en drop on the capture edge so each address sees exactly one read
        if (bus.uds_ready) begin
          state_d = S_OUT;
          cs_d    = 1'b0;
          en_d    = 1'b0;
          valid_d = 1'b1;
          data_d  = bus.uds_read_data;
          index_d = idx_q;
        end else if (cnt_q == TO_LAST) begin
          state_d = S_ERROR;
          error_d = 1'b1;
          busy_d  = 1'b0;
          cs_d    = 1'b0;
          en_d    = 1'b0;
          valid_d = 1'b0;
          data_d  = 32'd0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_OUT: begin
        if (bus.word_ready) begin
          valid_d = 1'b0;
          data_d  = 32'd0;
          if (idx_q == LAST_IDX) begin
            state_d = S_DONE;
            done_d  = 1'b1;
            busy_d  = 1'b0;
          end else begin
            state_d = S_REQ;
            idx_d   = idx_q + 3'd1;
            cnt_d   = 8'd0;
            cs_d    = 1'b1;
            en_d    = 1'b1;
            addr_d  = idx_q + 3'd1;
          end
        end
      end
      S_DONE:  ;
      S_ERROR: ;
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.error       = error_q;
  assign bus.uds_cs      = cs_q;
  assign bus.uds_en      = en_q;
  assign bus.uds_address = addr_q;
  assign bus.word_valid  = valid_q;
  assign bus.word_data   = data_q;
  assign bus.word_index  = index_q;
endmodule
